// File: rtl/ball_pkg.sv
// Ball controller shared types and constants.
// Holds the FSM state enum, move bit indices and pending-step codes.
package ball_pkg;
  localparam int COORD_W_DEF = 4;

  localparam int MV_XDEC = 0;
  localparam int MV_XINC = 1;
  localparam int MV_YDEC = 2;
  localparam int MV_YINC = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_X_RD,
    ST_X_WAIT,
    ST_Y_RD,
    ST_Y_WAIT
  } state_t;

  typedef enum logic [1:0] {
    PEND_NONE = 2'b00,
    PEND_INC  = 2'b01,
    PEND_DEC  = 2'b10
  } pend_t;
endpackage

// File: rtl/axis_pending.sv
// One axis pending-step register (none, +1, -1).
// Ports: i_inc/i_dec step pulses, i_consume, i_clear; o_pend code.
module axis_pending
  import ball_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_inc,
  input  logic       i_dec,
  input  logic       i_consume,
  input  logic       i_clear,
  output logic [1:0] o_pend
);
  pend_t r_pend;
  pend_t w_base;
  logic  w_set_inc;
  logic  w_set_dec;

  // A pulse landing on the consume edge applies to an empty register.
  always_comb begin
    w_base    = i_consume ? PEND_NONE : r_pend;
    w_set_inc = i_inc & ~i_dec;
    w_set_dec = i_dec & ~i_inc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_pend <= PEND_NONE;
    else if (i_clear)
      r_pend <= PEND_NONE;
    else if (w_set_inc)
      r_pend <= (w_base == PEND_DEC) ? PEND_NONE : PEND_INC;
    else if (w_set_dec)
      r_pend <= (w_base == PEND_INC) ? PEND_NONE : PEND_DEC;
    else
      r_pend <= w_base;
  end

  assign o_pend = r_pend;
endmodule

// File: rtl/ball_move_ctl.sv
// Labyrinth ball controller: latches tilt steps, checks map ROM, moves.
// Ports: move_pulses in, map_rd/map_addr/map_value ROM, ball_x/y, flags.
module ball_move_ctl
  import ball_pkg::*;
#(
  parameter int COORD_W     = COORD_W_DEF,
  parameter int START_X     = 1,
  parameter int START_Y     = 1,
  parameter int GOAL_X      = 14,
  parameter int GOAL_Y      = 14,
  parameter int MAP_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 restart,
  input  logic [3:0]           move_pulses,
  input  logic                 map_value,
  output logic [2*COORD_W-1:0] map_addr,
  output logic                 map_rd,
  output logic [COORD_W-1:0]   ball_x,
  output logic [COORD_W-1:0]   ball_y,
  output logic                 busy,
  output logic                 bump,
  output logic                 goal_reached
);
  localparam int CW = COORD_W + 1;
  localparam logic [1:0] LAT_LAST = 2'(MAP_LATENCY - 1);
  localparam logic [COORD_W-1:0] SX = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] SY = COORD_W'(START_Y);
  localparam logic [COORD_W-1:0] GX = COORD_W'(GOAL_X);
  localparam logic [COORD_W-1:0] GY = COORD_W'(GOAL_Y);

  state_t               r_state;
  logic [1:0]           r_cnt;
  logic [COORD_W-1:0]   r_x;
  logic [COORD_W-1:0]   r_y;
  logic [COORD_W-1:0]   r_cand;
  logic                 r_blk;
  logic                 r_rd;
  logic                 r_bump;
  logic                 r_goal;
  logic [2*COORD_W-1:0] r_addr;

  logic [1:0]           w_xp;
  logic [1:0]           w_yp;
  logic                 w_run;
  logic                 w_wait;
  logic                 w_last;
  logic                 w_commit;
  logic                 w_wall;
  logic                 w_goal_hit;
  logic                 w_x_go;
  logic                 w_y_go;
  logic [COORD_W-1:0]   w_bx;
  logic [COORD_W-1:0]   w_by;
  logic [CW-1:0]        w_xc;
  logic [CW-1:0]        w_yc;

  axis_pending u_x (
    .clk       (clk),
    .reset     (reset),
    .i_inc     (move_pulses[MV_XINC] & w_run),
    .i_dec     (move_pulses[MV_XDEC] & w_run),
    .i_consume (w_x_go),
    .i_clear   (~w_run),
    .o_pend    (w_xp)
  );

  axis_pending u_y (
    .clk       (clk),
    .reset     (reset),
    .i_inc     (move_pulses[MV_YINC] & w_run),
    .i_dec     (move_pulses[MV_YDEC] & w_run),
    .i_consume (w_y_go),
    .i_clear   (~w_run),
    .o_pend    (w_yp)
  );

  // w_bx/w_by are the coordinates after this edge, so a y lookup
  // launched on an x commit edge addresses the new column.
  always_comb begin
    w_run    = enable & ~r_goal & ~restart;
    w_wait   = (r_state == ST_X_WAIT) | (r_state == ST_Y_WAIT);
    w_last   = w_wait & (r_cnt == LAT_LAST);
    w_commit = w_last & ~map_value;
    w_wall   = w_last & map_value;
    w_bx     = r_x;
    w_by     = r_y;
    if (w_commit && r_state == ST_X_WAIT) w_bx = r_cand;
    if (w_commit && r_state == ST_Y_WAIT) w_by = r_cand;
    w_goal_hit = w_commit & (w_bx == GX) & (w_by == GY);

    // One extra bit: underflow and overflow both set the MSB.
    w_xc = {1'b0, w_bx};
    if (w_xp == PEND_INC) w_xc = w_xc + CW'(1);
    else if (w_xp == PEND_DEC) w_xc = w_xc - CW'(1);
    w_yc = {1'b0, w_by};
    if (w_yp == PEND_INC) w_yc = w_yc + CW'(1);
    else if (w_yp == PEND_DEC) w_yc = w_yc - CW'(1);

    w_x_go = 1'b0;
    w_y_go = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_x_go = w_run & (w_xp != PEND_NONE);
        w_y_go = w_run & (w_xp == PEND_NONE)
               & (w_yp != PEND_NONE);
      end
      ST_X_RD:
        w_y_go = r_blk & w_run & (w_yp != PEND_NONE);
      ST_X_WAIT:
        w_y_go = w_last & w_run & ~w_goal_hit
               & (w_yp != PEND_NONE);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_x     <= SX;
      r_y     <= SY;
      r_cand  <= '0;
      r_blk   <= 1'b0;
      r_rd    <= 1'b0;
      r_bump  <= 1'b0;
      r_goal  <= 1'b0;
      r_addr  <= '0;
    end else if (restart) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_x     <= SX;
      r_y     <= SY;
      r_rd    <= 1'b0;
      r_bump  <= 1'b0;
      r_goal  <= 1'b0;
    end else begin
      r_x    <= w_bx;
      r_y    <= w_by;
      r_rd   <= 1'b0;
      r_bump <= w_wall;
      if (w_goal_hit) r_goal <= 1'b1;
      if (w_x_go) begin
        r_state <= ST_X_RD;
        r_cand  <= w_xc[COORD_W-1:0];
        r_blk   <= w_xc[COORD_W];
        r_rd    <= ~w_xc[COORD_W];
        if (w_xc[COORD_W]) r_bump <= 1'b1;
        else r_addr <= {w_by, w_xc[COORD_W-1:0]};
      end else if (w_y_go) begin
        r_state <= ST_Y_RD;
        r_cand  <= w_yc[COORD_W-1:0];
        r_blk   <= w_yc[COORD_W];
        r_rd    <= ~w_yc[COORD_W];
        if (w_yc[COORD_W]) r_bump <= 1'b1;
        else r_addr <= {w_yc[COORD_W-1:0], w_bx};
      end else begin
        r_cnt <= '0;
        unique case (r_state)
          ST_X_RD:
            r_state <= r_blk ? ST_IDLE : ST_X_WAIT;
          ST_Y_RD:
            r_state <= r_blk ? ST_IDLE : ST_Y_WAIT;
          ST_X_WAIT, ST_Y_WAIT: begin
            if (w_last) r_state <= ST_IDLE;
            else r_cnt <= r_cnt + 2'd1;
          end
          default:
            r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign map_addr     = r_addr;
  assign map_rd       = r_rd;
  assign ball_x       = r_x;
  assign ball_y       = r_y;
  assign busy         = (r_state != ST_IDLE);
  assign bump         = r_bump;
  assign goal_reached = r_goal;
endmodule

// File: doc/ball_move_ctl.md
# ball_move_ctl

Ball position controller for the Labyrinth maze. It takes the 4-bit `move_pulses` stream from the accelerometer tilt block and latches pending steps per axis. It sequences one-step lookups into the shared maze map ROM and commits each step only if the target cell is free and on-grid. It owns the authoritative ball coordinates consumed by the display path, and flags bumps and goal arrival.

## Interface
- `COORD_W`, 4: coordinate width; grid is 2^COORD_W × 2^COORD_W cells.
- `START_X`, 1: ball x after reset or restart.
- `START_Y`, 1: ball y after reset or restart.
- `GOAL_X`, 14: goal cell x.
- `GOAL_Y`, 14: goal cell y.
- `MAP_LATENCY`, 1: cycles from `map_rd` high to `map_value` valid; legal range 1–3.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: game running; when low, pulses are ignored and pending steps are cleared.
- `restart` in 1: single-cycle request to return the ball to start.
- `move_pulses` in 4: single-cycle step requests. Bit [0] = x−, [1] = x+, [2] = y−, [3] = y+.
- `map_value` in 1: ROM data; 1 = wall, 0 = free.
- `map_addr` out 2·COORD_W: ROM address {y, x} of the candidate cell.
- `map_rd` out 1: ROM read strobe, one cycle per lookup.
- `ball_x` out COORD_W: current ball x.
- `ball_y` out COORD_W: current ball y.
- `busy` out 1: FSM not in IDLE.
- `bump` out 1: one-cycle pulse when a step is rejected by a wall or the grid edge.
- `goal_reached` out 1: sticky flag, set when the ball is on the goal cell.

## Operation
- Each axis has one pending register holding none, +1 or −1.
  - If a pulse sets both directions of an axis in the same cycle, it is ignored for that axis.
  - A pulse in the same direction as the pending step is dropped.
  - A pulse in the opposite direction clears the pending step.
  - Pulses arriving during a lookup on the same axis are latched normally; the in-flight lookup has already consumed its pending step.
- FSM states: IDLE, X_RD, X_WAIT, Y_RD, Y_WAIT.
  - IDLE → X_RD if an x step is pending, else → Y_RD if a y step is pending.
  - X_RD consumes the pending x step. If the candidate cell is outside 0..2^COORD_W−1, it pulses `bump` and goes to Y_RD or IDLE with no ROM access. Otherwise it asserts `map_rd` with `map_addr` = {ball_y, ball_x±1} and goes to X_WAIT.
  - X_WAIT counts MAP_LATENCY cycles and samples `map_value` on the last one. 0 commits `ball_x`; 1 pulses `bump`. Then → Y_RD if a y step is pending, else IDLE.
  - Y_RD and Y_WAIT mirror X_RD and X_WAIT, using address {ball_y±1, ball_x}, and always return to IDLE.
- Arithmetic: coordinate compute uses COORD_W+1 bits so the edge check sees underflow and overflow; values never wrap.
- `goal_reached` sets on the edge where a commit lands on (GOAL_X, GOAL_Y). While it is set, pulses are ignored and pending steps are cleared.
- `restart` has top priority:
  - aborts any lookup and returns the FSM to IDLE;
  - clears pending steps and `goal_reached`;
  - loads START_X and START_Y on the next edge.
- `enable` low: the FSM finishes any in-flight lookup, and no new lookup starts.
- `map_addr` holds its last value when `map_rd` is low.

## Timing
- Reset values:
  - `ball_x` = START_X, `ball_y` = START_Y;
  - `map_rd`, `busy`, `bump`, `goal_reached` = 0;
  - `map_addr` = 0;
  - FSM in IDLE, pending steps cleared.
- Pulse sampled at edge E0 sets the pending step. The FSM enters X_RD at E1, `map_rd` is high during E1–E2, and `ball_x` updates at E(2+MAP_LATENCY). With MAP_LATENCY = 1 that is E3.
- Simultaneous x and y pulses: x commits at E3, y commits at E5 (MAP_LATENCY = 1).
- An edge-blocked step costs one cycle in X_RD or Y_RD. `bump` is high in that cycle.
- `bump` is a registered one-cycle pulse, asserted in the cycle after the rejecting decision edge.
- `map_rd` is high for exactly one cycle per ROM lookup. Lookups never overlap.

## Structure
- Package `ball_pkg` holds:
  - COORD_W default;
  - the FSM state enum;
  - the move bit indices MV_XDEC = 0, MV_XINC = 1, MV_YDEC = 2, MV_YINC = 3;
  - the pending-step encoding (none, inc, dec).
- Sub-module `axis_pending` holds one axis's pending-step register, with set, cancel, consume and clear inputs. It is instantiated twice.
- The FSM, coordinate registers and goal compare live in the top module.

## Test plan
- Wall check: reset, `enable` = 1, pulse x+ with ROM cell {1,2} = 0 → `map_addr` = 8'h12 with `map_rd` at E1, `ball_x` = 2 at E3, `busy` low afterward.
- Wall hit: ROM {1,2} = 1, pulse x+ → `bump` pulse, `ball_x` stays 1.
- Edge: `ball_x` = 0, pulse x− → `bump`, no `map_rd` asserted, `ball_x` stays 0.
- Both axes: pulse 4'b1010 with both target cells free → x moves to 2 at E3, y moves to 2 at E5; a pulse of 4'b0011 changes nothing.
- Goal: walk the ball to (14,14) → `goal_reached` = 1 on the commit edge; further pulses ignored; `restart` → ball at (1,1) and `goal_reached` = 0 next edge.
- Restart mid-lookup with MAP_LATENCY = 3: assert `restart` during X_WAIT → no commit, FSM in IDLE, ball at start; async `reset` mid-lookup → all outputs return to reset values immediately.
